// File: rtl/data_sram_responder.sv
// Word-organised data memory for the core's data SRAM port: byte-enabled stores,
// fixed-latency loads with a valid strobe, sticky error flags and an access counter.
module data_sram_responder #(
  parameter int          ADDR_W       = 14,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h1c00_0000,
  parameter logic [31:0] CNT_RST_VAL  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_rvalid,
  output logic        err_be,
  output logic        err_oob,
  output logic [31:0] access_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase
  endfunction

  logic [31:0]       mem [DEPTH];

  logic [31:0]       off;
  logic [ADDR_W-1:0] idx;
  logic              oob;
  logic              rd_req;
  logic              wr_req;
  logic              be_bad;
  logic [31:0]       rd_word;

  logic [31:0]       cnt_q,     cnt_d;
  logic              err_be_q,  err_be_d;
  logic              err_oob_q, err_oob_d;

  logic              vld_q [READ_LATENCY];
  logic [31:0]       dat_q [READ_LATENCY];

  // Full 32-bit offset: anything below BASE_ADDR wraps high and lands out of range.
  always_comb begin
    off       = data_sram_addr - BASE_ADDR;
    idx       = off[ADDR_W+1:2];
    oob       = (off >> (ADDR_W + 2)) != 32'd0;
    rd_req    = data_sram_en && (data_sram_we == 4'b0000);
    wr_req    = data_sram_en && be_legal(data_sram_we);
    be_bad    = data_sram_en && (data_sram_we != 4'b0000) && !be_legal(data_sram_we);
    rd_word   = oob ? 32'd0 : mem[idx];
    cnt_d     = data_sram_en ? cnt_q + 32'd1 : cnt_q;
    err_be_d  = err_be_q | be_bad;
    err_oob_d = err_oob_q | (data_sram_en & oob);
  end

  // Storage array: no reset, contents survive resetn.
  always_ff @(posedge clk) begin
    if (wr_req && !oob) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) begin
          mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read pipeline: data stages only load behind a valid entry so rdata holds when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= 32'd0;
      end
      cnt_q     <= CNT_RST_VAL;
      err_be_q  <= 1'b0;
      err_oob_q <= 1'b0;
    end else begin
      vld_q[0] <= rd_req;
      if (rd_req) begin
        dat_q[0] <= rd_word;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
      cnt_q     <= cnt_d;
      err_be_q  <= err_be_d;
      err_oob_q <= err_oob_d;
    end
  end

  assign data_sram_rdata  = dat_q[READ_LATENCY-1];
  assign data_sram_rvalid = vld_q[READ_LATENCY-1];
  assign err_be           = err_be_q;
  assign err_oob          = err_oob_q;
  assign access_cnt       = cnt_q;

endmodule
